arpas_sched4: RTL and testbench

Round-robin scheduler for the 4-way ARPAS signal demultiplexer (2-bit increment-only binary counter driving a one-hot select decoder and an AND gating array). It arbitrates among four destination requesters and steps the datapath counter to the winner's index with well-formed `inc` pulses. It then gates `data_in` onto `sig` for a programmable dwell window. It sits directly in front of the demux and is the only driver of its `inc` and `sig` inputs.

---
 rtl/arpas_sched4.sv | 109 ++++++++++
 tb/tb_arpas_sched4.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/arpas_sched4.sv
// rtl/arpas_sched4.sv - round-robin scheduler stepping the ARPAS 4-way demux counter
// Steps the demux select with clean inc pulses, then gates data_in onto sig for a dwell window.
module arpas_sched4 #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic       c,
  input  logic       r,
  input  logic [3:0] req,
  input  logic       data_in,
  output logic       inc,
  output logic       sig,
  output logic [3:0] gnt,
  output logic [1:0] cur_sel,
  output logic       busy,
  output logic       done
);

  localparam logic [DWELL_W-1:0] DW_MAX = (DWELL == 0) ? DWELL_W'(1) : DWELL_W'(DWELL);

  typedef enum logic [1:0] {IDLE, STEP_HI, STEP_LO, DWELL_ST} state_t;

  state_t             state;
  logic [1:0]         tgt;
  logic [1:0]         last;
  logic [1:0]         winner;
  logic [DWELL_W-1:0] cnt;
  logic               final_cyc;

  // First set request bit scanning upward from the slot after the last grant.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    winner = last + 2'd1;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign final_cyc = (state == DWELL_ST) && ((cnt >= DW_MAX) || !req[tgt]);
  assign done      = final_cyc;
  assign sig       = (state == DWELL_ST) & data_in;

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      state   <= IDLE;
      inc     <= 1'b0;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      cur_sel <= 2'd0;
      last    <= 2'd3;
      tgt     <= 2'd0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            tgt  <= winner;
            busy <= 1'b1;
            if (winner == cur_sel) begin
              state <= DWELL_ST;
              gnt   <= 4'b0001 << winner;
              cnt   <= DWELL_W'(1);
            end else begin
              state   <= STEP_HI;
              inc     <= 1'b1;
              cur_sel <= cur_sel + 2'd1;
            end
          end
        end
        STEP_HI: begin
          state <= STEP_LO;
          inc   <= 1'b0;
        end
        STEP_LO: begin
          if (cur_sel == tgt) begin
            state <= DWELL_ST;
            gnt   <= 4'b0001 << tgt;
            cnt   <= DWELL_W'(1);
          end else begin
            // The shadow copy moves on the same edge the demux counter sees inc rise.
            state   <= STEP_HI;
            inc     <= 1'b1;
            cur_sel <= cur_sel + 2'd1;
          end
        end
        DWELL_ST: begin
          if (final_cyc) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            cnt   <= '0;
            last  <= tgt;
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arpas_sched4.sv
// tb/tb_arpas_sched4.sv - self-checking bench for arpas_sched4
// Cycle table for reset/step/wrap/release, then fairness and mid-step reset sequences.
module tb_arpas_sched4;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       data_in = 1'b0;
  logic       inc, sig, busy, done;
  logic [3:0] gnt;
  logic [1:0] cur_sel;

  int ncmp = 0;
  int nerr = 0;

  arpas_sched4 #(.DWELL(4), .DWELL_W(8)) dut (
    .c(c), .r(r), .req(req), .data_in(data_in),
    .inc(inc), .sig(sig), .gnt(gnt), .cur_sel(cur_sel), .busy(busy), .done(done)
  );

  always #5 c = ~c;

  typedef struct {
    logic       r;
    logic [3:0] req;
    logic       d;
    logic       inc;
    logic       sig;
    logic [3:0] gnt;
    logic [1:0] cs;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(logic rr, logic [3:0] q, logic d, logic i, logic s,
                              logic [3:0] g, logic [1:0] cs, logic b, logic dn);
    vec_t v;
    v.r = rr; v.req = q; v.d = d; v.inc = i; v.sig = s;
    v.gnt = g; v.cs = cs; v.busy = b; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rr, input logic [3:0] q, input logic dd);
    @(posedge c);
    #2;
    r = rr; req = q; data_in = dd;
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] act, exp;
    int pulses, ngr, lastc, prevg;
    int exp_idx [5];
    int exp_pul [5];

    //                r   req    d  inc sig gnt    cs   busy done
    tbl[0]  = mk(1, 4'b0001, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
    tbl[1]  = mk(0, 4'b0001, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
    tbl[2]  = mk(0, 4'b0001, 1, 0, 1, 4'b0001, 2'd0, 1, 0);
    tbl[3]  = mk(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0);
    tbl[4]  = mk(0, 4'b0001, 1, 0, 1, 4'b0001, 2'd0, 1, 0);
    tbl[5]  = mk(0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 1);
    tbl[6]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
    tbl[7]  = mk(0, 4'b0100, 1, 0, 0, 4'b0000, 2'd0, 0, 0);
    tbl[8]  = mk(0, 4'b0100, 1, 1, 0, 4'b0000, 2'd1, 1, 0);
    tbl[9]  = mk(0, 4'b0100, 1, 0, 0, 4'b0000, 2'd1, 1, 0);
    tbl[10] = mk(0, 4'b0100, 1, 1, 0, 4'b0000, 2'd2, 1, 0);
    tbl[11] = mk(0, 4'b0100, 1, 0, 0, 4'b0000, 2'd2, 1, 0);
    tbl[12] = mk(0, 4'b0100, 1, 0, 1, 4'b0100, 2'd2, 1, 0);
    tbl[13] = mk(0, 4'b0100, 0, 0, 0, 4'b0100, 2'd2, 1, 0);
    tbl[14] = mk(0, 4'b0100, 1, 0, 1, 4'b0100, 2'd2, 1, 0);
    tbl[15] = mk(0, 4'b0100, 1, 0, 1, 4'b0100, 2'd2, 1, 1);
    tbl[16] = mk(0, 4'b1000, 1, 0, 0, 4'b0000, 2'd2, 0, 0);
    tbl[17] = mk(0, 4'b1000, 0, 1, 0, 4'b0000, 2'd3, 1, 0);
    tbl[18] = mk(0, 4'b1000, 0, 0, 0, 4'b0000, 2'd3, 1, 0);
    tbl[19] = mk(0, 4'b1000, 0, 0, 0, 4'b1000, 2'd3, 1, 0);
    tbl[20] = mk(0, 4'b1000, 1, 0, 1, 4'b1000, 2'd3, 1, 0);
    tbl[21] = mk(0, 4'b1000, 0, 0, 0, 4'b1000, 2'd3, 1, 0);
    tbl[22] = mk(0, 4'b1000, 0, 0, 0, 4'b1000, 2'd3, 1, 1);
    tbl[23] = mk(0, 4'b0010, 0, 0, 0, 4'b0000, 2'd3, 0, 0);
    tbl[24] = mk(0, 4'b1010, 0, 1, 0, 4'b0000, 2'd0, 1, 0);
    tbl[25] = mk(0, 4'b1010, 0, 0, 0, 4'b0000, 2'd0, 1, 0);
    tbl[26] = mk(0, 4'b1010, 0, 1, 0, 4'b0000, 2'd1, 1, 0);
    tbl[27] = mk(0, 4'b1010, 0, 0, 0, 4'b0000, 2'd1, 1, 0);
    tbl[28] = mk(0, 4'b0010, 1, 0, 1, 4'b0010, 2'd1, 1, 0);
    tbl[29] = mk(0, 4'b0000, 1, 0, 1, 4'b0010, 2'd1, 1, 1);
    tbl[30] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 2'd1, 0, 0);

    for (int i = 0; i < 31; i++) begin
      step(tbl[i].r, tbl[i].req, tbl[i].d);
      act = {inc, sig, gnt, cur_sel, busy, done};
      exp = {tbl[i].inc, tbl[i].sig, tbl[i].gnt, tbl[i].cs, tbl[i].busy, tbl[i].done};
      chk($sformatf("row%0d {inc,sig,gnt,cs,busy,done}", i), 16'(act), 16'(exp));
    end

    // Fairness with all four requesting continuously, starting from reset.
    exp_idx = '{0, 1, 2, 3, 0};
    exp_pul = '{0, 1, 1, 1, 1};
    step(1, 4'hf, 0);
    pulses = 0; ngr = 0; lastc = 0; prevg = 0;
    for (int cyc = 0; cyc < 100 && ngr < 5; cyc++) begin
      step(0, 4'hf, 0);
      if (inc) pulses++;
      if (gnt != 4'b0000 && prevg == 0) begin
        chk($sformatf("rr_gnt%0d", ngr), 16'(gnt), 16'(4'b0001 << exp_idx[ngr]));
        chk($sformatf("rr_pulses%0d", ngr), 16'(pulses), 16'(exp_pul[ngr]));
        if (ngr > 0) chk($sformatf("rr_period%0d", ngr), 16'(cyc - lastc), 16'd7);
        lastc = cyc;
        pulses = 0;
        ngr++;
      end
      prevg = int'(gnt);
    end
    if (ngr < 5) begin
      ncmp++; nerr++;
      $display("FAIL rr_timeout: got %0d grants expected 5", ngr);
    end

    // Early release of grant 0 in its second dwell cycle.
    step(0, 4'b1110, 0);
    chk("early_done {gnt,done}", 16'({gnt, done}), 16'(5'b00011));
    step(0, 4'b0000, 0);
    chk("early_idle {busy,gnt}", 16'({busy, gnt}), 16'(5'b00000));

    // Reset while inc is high in the first STEP_HI.
    step(0, 4'b0100, 1);
    step(0, 4'b0100, 1);
    chk("pre_rst {inc,cs,busy}", 16'({inc, cur_sel, busy}), 16'(4'b1011));
    #1 r = 1'b1;
    #1;
    chk("async_rst {inc,gnt,busy,sig,cs}", 16'({inc, gnt, busy, sig, cur_sel}), 16'(0));
    step(1, 4'b0000, 1);
    step(0, 4'b1000, 1);
    pulses = 0; ngr = 0;
    for (int cyc = 0; cyc < 20 && ngr == 0; cyc++) begin
      step(0, 4'b1000, 1);
      if (inc) pulses++;
      if (gnt != 4'b0000) ngr = 1;
    end
    chk("post_rst_pulses", 16'(pulses), 16'd3);
    chk("post_rst {gnt,cs}", 16'({gnt, cur_sel}), 16'(6'b100011));
    step(0, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
